// File: rtl/md_seq.sv
// md_seq: HI/LO multiply/divide sequencer with fixed 5/10-cycle latency.
// Define MD_FLUSH_EN to let flush suppress a same-cycle start.
module md_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  input  logic        d_md_use,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        stall_md
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [3:0]  cnt;
  logic [31:0] res_hi, res_lo;
  logic        dz, go, load, mt_hi, mt_lo, commit;
  logic [63:0] ma, mb, prod;
  logic        neg_a, neg_b;
  logic [31:0] da, db, q, r;
`ifdef MD_FLUSH_EN
  assign go = start & ~flush;
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign go = start;
`endif
  assign busy = state == RUN;
  assign stall_md = d_md_use & ((start & ~op[2]) | busy);
  // mult and multu share one 64-bit multiplier; only the operand extension differs
  assign ma = {{32{rs_val[31] & ~op[0]}}, rs_val};
  assign mb = {{32{rt_val[31] & ~op[0]}}, rt_val};
  assign prod = ma * mb;
  // signed division on magnitudes, so 0x80000000 / -1 wraps cleanly to 0x80000000
  assign neg_a = ~op[0] & rs_val[31];
  assign neg_b = ~op[0] & rt_val[31];
  assign da = neg_a ? -rs_val : rs_val;
  assign db = neg_b ? -rt_val : rt_val;
  assign q = (db == 32'd0) ? 32'd0 : da / db;
  assign r = (db == 32'd0) ? 32'd0 : da % db;
  always_comb begin
    load = go && state == IDLE && op[2:1] != 2'b10 && !op[2];
    mt_hi = go && state == IDLE && op == 3'd4;
    mt_lo = go && state == IDLE && op == 3'd5;
    commit = busy && cnt == 4'd0;
    state_n = load ? RUN : commit ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      done <= 1'b0;
      res_hi <= '0;
      res_lo <= '0;
      dz <= 1'b0;
    end else begin
      state <= state_n;
      done <= commit;
      if (load) begin
        cnt <= op[1] ? 4'd9 : 4'd4;
        res_hi <= op[1] ? (neg_a ? -r : r) : prod[63:32];
        res_lo <= op[1] ? ((neg_a ^ neg_b) ? -q : q) : prod[31:0];
        dz <= op[1] && rt_val == 32'd0;
      end else if (busy && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit && !dz) begin
        hi <= res_hi;
        lo <= res_lo;
      end
      if (mt_hi) hi <= rs_val;
      if (mt_lo) lo <= rs_val;
    end
  end
endmodule

// File: tb/tb_md_seq.sv
// tb_md_seq: directed self-checking bench for md_seq.
module tb_md_seq;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, flush = 1'b0, d_md_use = 1'b0;
  logic [2:0] op = 3'd0;
  logic [31:0] rs_val = '0, rt_val = '0;
  logic [31:0] hi, lo;
  logic busy, done, stall_md;
  int cmp = 0, mis = 0;
  md_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .flush(flush), .d_md_use(d_md_use), .hi(hi), .lo(lo), .busy(busy), .done(done),
    .stall_md(stall_md)
  );
  always #5 clk = ~clk;

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic f);
    start = 1'b1; op = o; rs_val = a; rt_val = b; flush = f;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
  endtask

  task automatic wait_idle(output int n, output int ov);
    n = 0; ov = 0;
    while (busy && n < 30) begin
      if (done) ov++;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    cmp++;
    if (got !== exp) begin
      mis++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_stall", {31'b0, stall_md}, 32'h0);
  endtask

  task automatic test_mult;
    int n, ov;
    d_md_use = 1'b1; start = 1'b1; op = 3'd0; rs_val = 32'hFFFFFFFF; rt_val = 32'd2;
    #1 chk("mult_stall_start", {31'b0, stall_md}, 32'h1);
    @(negedge clk);
    start = 1'b0;
    chk("mult_stall_busy", {31'b0, stall_md}, 32'h1);
    d_md_use = 1'b0;
    wait_idle(n, ov);
    chk("mult_cycles", n, 32'd5);
    chk("mult_overlap", ov, 32'd0);
    chk("mult_done", {31'b0, done}, 32'h1);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFE);
    @(negedge clk);
    chk("mult_done_pulse", {31'b0, done}, 32'h0);
    issue(3'd1, 32'hFFFFFFFF, 32'd2, 1'b0);
    wait_idle(n, ov);
    chk("multu_hi", hi, 32'h1);
    chk("multu_lo", lo, 32'hFFFFFFFE);
    issue(3'd0, -32'sd3, 32'd5, 1'b0);
    wait_idle(n, ov);
    chk("mult_neg_hi", hi, 32'hFFFFFFFF);
    chk("mult_neg_lo", lo, 32'hFFFFFFF1);
  endtask

  task automatic test_div;
    int n, ov;
    issue(3'd3, 32'd7, 32'd2, 1'b0);
    wait_idle(n, ov);
    chk("divu_cycles", n, 32'd10);
    chk("divu_overlap", ov, 32'd0);
    chk("divu_done", {31'b0, done}, 32'h1);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);
    issue(3'd2, -32'sd7, 32'd2, 1'b0);
    wait_idle(n, ov);
    chk("div_neg_lo", lo, 32'hFFFFFFFD);
    chk("div_neg_hi", hi, 32'hFFFFFFFF);
    issue(3'd2, -32'sd7, -32'sd2, 1'b0);
    wait_idle(n, ov);
    chk("div_nn_lo", lo, 32'd3);
    chk("div_nn_hi", hi, 32'hFFFFFFFF);
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    wait_idle(n, ov);
    chk("div_ovf_lo", lo, 32'h80000000);
    chk("div_ovf_hi", hi, 32'h0);
  endtask

  task automatic test_div_zero;
    int n, ov;
    issue(3'd4, 32'h11, 32'h0, 1'b0);
    issue(3'd5, 32'h22, 32'h0, 1'b0);
    issue(3'd2, 32'd9, 32'd0, 1'b0);
    wait_idle(n, ov);
    chk("dz_cycles", n, 32'd10);
    chk("dz_done", {31'b0, done}, 32'h1);
    chk("dz_hi", hi, 32'h11);
    chk("dz_lo", lo, 32'h22);
  endtask

  task automatic test_mthi;
    d_md_use = 1'b1; start = 1'b1; op = 3'd4; rs_val = 32'hABCD;
    #1 chk("mthi_stall", {31'b0, stall_md}, 32'h0);
    @(negedge clk);
    start = 1'b0;
    chk("mthi_hi", hi, 32'hABCD);
    chk("mthi_lo_kept", lo, 32'h22);
    chk("mthi_busy", {31'b0, busy}, 32'h0);
    chk("mthi_done", {31'b0, done}, 32'h0);
    chk("mthi_stall_after", {31'b0, stall_md}, 32'h0);
    d_md_use = 1'b0;
  endtask

  task automatic test_ignored;
    int n, ov;
    issue(3'd6, 32'h5555, 32'h3, 1'b0);
    issue(3'd7, 32'h6666, 32'h3, 1'b0);
    chk("op67_busy", {31'b0, busy}, 32'h0);
    chk("op67_hi", hi, 32'hABCD);
    chk("op67_lo", lo, 32'h22);
    issue(3'd1, 32'd3, 32'd4, 1'b0);
    @(negedge clk);
    issue(3'd4, 32'hDEAD, 32'h0, 1'b0);
    wait_idle(n, ov);
    chk("run_start_cycles", n, 32'd3);
    chk("run_start_hi", hi, 32'h0);
    chk("run_start_lo", lo, 32'd12);
  endtask

  task automatic test_flush;
    int n, ov;
    issue(3'd1, 32'd2, 32'd3, 1'b1);
`ifdef MD_FLUSH_EN
    chk("flush_busy", {31'b0, busy}, 32'h0);
    chk("flush_hi", hi, 32'h0);
    chk("flush_lo", lo, 32'd12);
    issue(3'd4, 32'h77, 32'h0, 1'b1);
    chk("flush_mthi", hi, 32'h0);
`else
    wait_idle(n, ov);
    chk("noflush_cycles", n, 32'd5);
    chk("noflush_lo", lo, 32'd6);
    chk("noflush_hi", hi, 32'h0);
`endif
  endtask

  task automatic test_reset_run;
    int bad;
    issue(3'd4, 32'h99, 32'h0, 1'b0);
    issue(3'd3, 32'd100, 32'd7, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rrun_busy", {31'b0, busy}, 32'h0);
    chk("rrun_hi", hi, 32'h0);
    chk("rrun_lo", lo, 32'h0);
    bad = 0;
    repeat (15) begin
      if (done || busy || hi != 32'h0 || lo != 32'h0) bad++;
      @(negedge clk);
    end
    chk("rrun_no_commit", bad, 32'd0);
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_mult;
    test_div;
    test_div_zero;
    test_mthi;
    test_ignored;
    test_flush;
    test_reset_run;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end
endmodule
